// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its two-requester arbiter.
//   WIDTH            default operand/result width
//   OP_ADD..OP_NOT   ALUOp encodings (101-111 are illegal)
//   state_t          arbiter FSM states
//   op_legal()       true for the five defined op codes
package alu_pkg;

    localparam int unsigned WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/alu.sv
// alu: the shared combinational ALU.
//   A, B    operands
//   ALUOp   operation select (ADD, SUB, AND, OR, NOT A)
//   Result  result modulo 2^WIDTH; 0 for undefined op codes
//   Zero    high when Result is zero
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] Result,
    output logic             Zero
);

    always_comb begin
        Result = '0;
        case (ALUOp)
            OP_ADD:  Result = A + B;
            OP_SUB:  Result = A - B;
            OP_AND:  Result = A & B;
            OP_OR:   Result = A | B;
            OP_NOT:  Result = ~A;
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with round-robin grants.
//   clk, rst             clock; asynchronous active-high reset
//   req_valid/req_ready  per-requester request handshake (bit n = requester n)
//   req_a*/req_b*/req_op* operands and op code of each requester
//   resp_valid/resp_ready per-requester response handshake
//   resp_result/zero/err registered result, Zero flag, illegal-op flag
//   busy                 high whenever the FSM is not IDLE
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = alu_pkg::WIDTH,
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err,
    output logic             busy
);

    state_t           state_q, state_d;
    logic             ptr_q;
    logic             win_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             err_q;

    logic             any_req;
    logic             gnt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    alu #(.WIDTH(WIDTH)) u_alu (
        .A      (a_q),
        .B      (b_q),
        .ALUOp  (op_q),
        .Result (alu_result),
        .Zero   (alu_zero)
    );

    assign any_req = |req_valid;
    // Requester 1 wins when it is the only one asking, or both ask and it holds priority.
    assign gnt = req_valid[1] & (~req_valid[0] | ptr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        resp_valid = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    req_ready[gnt] = 1'b1;
                    state_d        = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                resp_valid[win_q] = 1'b1;
                if (resp_ready[win_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= 1'(PRIO_INIT);
            win_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_q <= gnt;
                        a_q   <= gnt ? req_a1  : req_a0;
                        b_q   <= gnt ? req_b1  : req_b0;
                        op_q  <= gnt ? req_op1 : req_op0;
                    end
                end
                EXEC: begin
                    // Illegal ops report a forced zero result rather than the ALU output.
                    if (op_legal(op_q)) begin
                        result_q <= alu_result;
                        zero_q   <= alu_zero;
                        err_q    <= 1'b0;
                    end else begin
                        result_q <= '0;
                        zero_q   <= 1'b1;
                        err_q    <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready[win_q]) ptr_q <= ~win_q;
                end
                default: ;
            endcase
        end
    end

    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign resp_err    = err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a0, req_a1, req_b0, req_b1;
    logic [2:0]  req_op0, req_op1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [15:0] resp_result;
    logic        resp_zero;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int prio   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(16), .PRIO_INIT(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a0      (req_a0),
        .req_a1      (req_a1),
        .req_b0      (req_b0),
        .req_b1      (req_b1),
        .req_op0     (req_op0),
        .req_op1     (req_op1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns {err, zero, result} straight from the op-code table.
    function automatic logic [17:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [15:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~a;
            default: return {1'b1, 1'b1, 16'h0000};
        endcase
        return {1'b0, (r == 16'h0000), r};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(req_ready),   32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid),  32'd0);
        check({tag, "_result"},     32'(resp_result), 32'd0);
        check({tag, "_zero"},       32'(resp_zero),   32'd0);
        check({tag, "_err"},        32'(resp_err),    32'd0);
        check({tag, "_busy"},       32'(busy),        32'd0);
    endtask

    // Serves one transaction from the current request set, with the winner's
    // resp_ready held low for 'stall' RESP cycles. The other resp_ready bit is
    // held high throughout, since the arbiter must ignore it.
    task automatic serve_one(input int stall);
        int          w;
        logic [1:0]  oh;
        logic [17:0] e;
        #1;
        if (req_valid == 2'b11) w = prio;
        else if (req_valid[1])  w = 1;
        else                    w = 0;
        oh = (w == 1) ? 2'b10 : 2'b01;
        e  = (w == 1) ? ref_alu(req_op1, req_a1, req_b1) : ref_alu(req_op0, req_a0, req_b0);
        check("grant", 32'(req_ready), 32'(oh));
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);
        step();
        req_valid[w] = 1'b0;
        resp_ready   = (stall > 0) ? ~oh : 2'b11;
        #1;
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_resp_valid", 32'(resp_valid), 32'd0);
        check("exec_req_ready", 32'(req_ready), 32'd0);
        step();
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) begin
                resp_ready = 2'b11;
                #1;
            end
            check("resp_valid", 32'(resp_valid), 32'(oh));
            check("resp_result", 32'(resp_result), 32'(e[15:0]));
            check("resp_zero", 32'(resp_zero), 32'(e[16]));
            check("resp_err", 32'(resp_err), 32'(e[17]));
            check("resp_busy", 32'(busy), 32'd1);
            check("resp_req_ready", 32'(req_ready), 32'd0);
            if (i < stall) step();
        end
        step();
        resp_ready = 2'b00;
        prio = 1 - w;
        check("back_idle_busy", 32'(busy), 32'd0);
        check("back_idle_resp_valid", 32'(resp_valid), 32'd0);
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b);
        if (r == 1) begin
            req_op1 = op; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
        end else begin
            req_op0 = op; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        req_op0 = '0; req_op1 = '0;
        #1;
        check_reset_outputs("reset");
        step();
        step();
        rst = 1'b0;
        prio = 0;

        // Simultaneous pairs: requester 0 first each time
        set_req(0, 3'd2, 16'h00FF, 16'h0F0F);
        set_req(1, 3'd3, 16'h00FF, 16'h0F0F);
        serve_one(0);
        check("pair1_r0_result", 32'(resp_result), 32'h000F);
        serve_one(0);
        check("pair1_r1_result", 32'(resp_result), 32'h0FFF);
        set_req(0, 3'd2, 16'h00FF, 16'h0F0F);
        set_req(1, 3'd3, 16'h00FF, 16'h0F0F);
        #1;
        check("pair2_first_grant", 32'(req_ready), 32'd1);
        serve_one(0);
        serve_one(0);

        // Single ADD
        set_req(0, 3'd0, 16'h000A, 16'h0005);
        serve_one(0);
        check("add_result", 32'(resp_result), 32'h000F);
        check("add_zero", 32'(resp_zero), 32'd0);

        // Wrap and zero flag
        set_req(1, 3'd0, 16'hFFFF, 16'h0001);
        serve_one(0);
        check("wrap_result", 32'(resp_result), 32'h0000);
        check("wrap_zero", 32'(resp_zero), 32'd1);
        set_req(0, 3'd1, 16'h000A, 16'h000A);
        serve_one(0);
        check("sub_zero", 32'(resp_zero), 32'd1);
        set_req(1, 3'd4, 16'h00FF, 16'h1234);
        serve_one(0);
        check("not_result", 32'(resp_result), 32'hFF00);
        check("not_zero", 32'(resp_zero), 32'd0);

        // Back-pressure with the other requester waiting
        set_req(0, 3'd0, 16'h1111, 16'h2222);
        set_req(1, 3'd1, 16'h5000, 16'h0001);
        serve_one(3);
        serve_one(2);

        // Illegal op, then a legal op clears err
        set_req(0, 3'd6, 16'h1234, 16'h5678);
        serve_one(0);
        check("illegal_err", 32'(resp_err), 32'd1);
        check("illegal_result", 32'(resp_result), 32'h0000);
        set_req(1, 3'd3, 16'h0001, 16'h0002);
        serve_one(0);
        check("legal_clears_err", 32'(resp_err), 32'd0);

        // Reset during EXEC with the pointer at requester 1
        set_req(0, 3'd0, 16'h0001, 16'h0001);
        serve_one(0);
        set_req(1, 3'd0, 16'h00A0, 16'h000B);
        #1;
        check("pre_reset_grant", 32'(req_ready), 32'd2);
        step();
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        #1;
        check("in_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        step();
        check_reset_outputs("mid_reset_held");
        rst  = 1'b0;
        prio = 0;
        step();
        check("no_resp_after_reset", 32'(resp_valid), 32'd0);
        resp_ready = 2'b00;
        set_req(0, 3'd3, 16'hF000, 16'h000F);
        set_req(1, 3'd2, 16'hFFFF, 16'h1234);
        serve_one(0);
        check("post_reset_prio_result", 32'(resp_result), 32'hF00F);
        serve_one(1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && $urandom_range(0, 2) != 0) begin
                    logic [15:0] a, b;
                    a = 16'($urandom);
                    b = ($urandom_range(0, 4) == 0) ? a : 16'($urandom);
                    if ($urandom_range(0, 5) == 0) a = 16'hFFFF;
                    set_req(r, 3'($urandom_range(0, 7)), a, b);
                end
            end
            if (req_valid == 2'b00) begin
                #1;
                check("idle_no_grant", 32'(req_ready), 32'd0);
                check("idle_not_busy", 32'(busy), 32'd0);
                step();
            end else begin
                serve_one(int'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
